imem_controller: RTL and testbench

// Single-port access controller for the 256x8 instruction memory. Arbitrates between a

---
 rtl/imem_controller.sv | 96 +++++++++
 tb/tb_imem_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imem_controller.sv
// Single-port 256x8 instruction memory access controller: loader writes vs CPU fetch reads.
// Write occupies 2 cycles, read 3 (fe_valid 2 cycles after fe_ack); requesters hold req until their ack.
module imem_controller #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MAX_LD_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_add,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic              fe_req,
    input  logic [ADDR_W-1:0] fe_add,
    output logic              fe_ack,
    output logic              fe_valid,
    output logic [DATA_W-1:0] fe_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_ip,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_op
);

    localparam int CNT_W = $clog2(MAX_LD_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LD_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ld_ack     <= 1'b0;
            fe_ack     <= 1'b0;
            fe_valid   <= 1'b0;
            fe_data    <= '0;
            busy       <= 1'b0;
            mem_add    <= '0;
            mem_ip     <= '0;
            mem_rw     <= 1'b1;
        end else begin
            ld_ack   <= 1'b0;
            fe_ack   <= 1'b0;
            fe_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Loader may only starve a pending fetch for MAX_LD_BURST grants in a row.
                    if (ld_req && (!fe_req || starve_cnt < MAX_CNT)) begin
                        mem_add    <= ld_add;
                        mem_ip     <= ld_data;
                        mem_rw     <= 1'b0;
                        ld_ack     <= 1'b1;
                        busy       <= 1'b1;
                        starve_cnt <= fe_req ? starve_cnt + CNT_W'(1) : '0;
                        state      <= WRITE;
                    end else if (fe_req) begin
                        mem_add    <= fe_add;
                        mem_rw     <= 1'b1;
                        fe_ack     <= 1'b1;
                        busy       <= 1'b1;
                        starve_cnt <= '0;
                        state      <= READ;
                    end else begin
                        mem_rw <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_rw <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    fe_data  <= mem_op;
                    fe_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_controller.sv
// Directed bench for imem_controller with a behavioural 256x8 memory (registered read, mem[0] cleared in reset).
module tb_imem_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_req, fe_req;
    logic [7:0] ld_add, ld_data, fe_add;
    logic       ld_ack, fe_ack, fe_valid, busy, mem_rw;
    logic [7:0] fe_data, mem_add, mem_ip, mem_op;

    logic [7:0] mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_controller #(.ADDR_W(8), .DATA_W(8), .MAX_LD_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_add(ld_add), .ld_data(ld_data), .ld_ack(ld_ack),
        .fe_req(fe_req), .fe_add(fe_add), .fe_ack(fe_ack),
        .fe_valid(fe_valid), .fe_data(fe_data), .busy(busy),
        .mem_add(mem_add), .mem_ip(mem_ip), .mem_rw(mem_rw), .mem_op(mem_op)
    );

    always @(posedge clk) begin
        if (reset) mem[0] <= 8'h00;
        else if (!mem_rw) mem[mem_add] <= mem_ip;
        else mem_op <= mem[mem_add];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ld_ack"},   32'(ld_ack),   32'h0);
        chk({tag, ".fe_ack"},   32'(fe_ack),   32'h0);
        chk({tag, ".fe_valid"}, 32'(fe_valid), 32'h0);
        chk({tag, ".fe_data"},  32'(fe_data),  32'h0);
        chk({tag, ".busy"},     32'(busy),     32'h0);
        chk({tag, ".mem_add"},  32'(mem_add),  32'h0);
        chk({tag, ".mem_ip"},   32'(mem_ip),   32'h0);
        chk({tag, ".mem_rw"},   32'(mem_rw),   32'h1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_op  = 8'h00;
        reset   = 1'b1;
        ld_req  = 1'b0; ld_add = 8'h00; ld_data = 8'h00;
        fe_req  = 1'b0; fe_add = 8'h00;

        // 1. reset values, then idle stability
        tick(); tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick(); tick(); tick();
        chk_reset_vals("idle");

        // 2. write 0xA5 to 0x10, read it back
        ld_req = 1'b1; ld_add = 8'h10; ld_data = 8'hA5;
        tick();
        chk("wr.ld_ack",  32'(ld_ack),  32'h1);
        chk("wr.mem_rw",  32'(mem_rw),  32'h0);
        chk("wr.mem_add", 32'(mem_add), 32'h10);
        chk("wr.mem_ip",  32'(mem_ip),  32'hA5);
        chk("wr.busy",    32'(busy),    32'h1);
        ld_req = 1'b0;
        tick();
        chk("wr2.ld_ack", 32'(ld_ack), 32'h0);
        chk("wr2.mem_rw", 32'(mem_rw), 32'h1);
        chk("wr2.busy",   32'(busy),   32'h0);
        fe_req = 1'b1; fe_add = 8'h10;
        tick();
        chk("rd.fe_ack",  32'(fe_ack),  32'h1);
        chk("rd.mem_add", 32'(mem_add), 32'h10);
        chk("rd.mem_rw",  32'(mem_rw),  32'h1);
        fe_req = 1'b0;
        tick();
        chk("rd1.fe_ack",   32'(fe_ack),   32'h0);
        chk("rd1.fe_valid", 32'(fe_valid), 32'h0);
        tick();
        chk("rd2.fe_valid", 32'(fe_valid), 32'h1);
        chk("rd2.fe_data",  32'(fe_data),  32'hA5);
        tick();
        chk("rd3.fe_valid", 32'(fe_valid), 32'h0);
        chk("rd3.fe_data",  32'(fe_data),  32'hA5);

        // 3. both requests held: 4 loader grants, 1 fetch grant, repeat
        ld_req = 1'b1; ld_add = 8'h80; ld_data = 8'h00;
        fe_req = 1'b1; fe_add = 8'h80;
        for (int k = 0; k < 22; k++) begin
            logic exp_ld, exp_fe;
            tick();
            exp_ld = (k == 0 || k == 2 || k == 4 || k == 6 ||
                      k == 11 || k == 13 || k == 15 || k == 17);
            exp_fe = (k == 8 || k == 19);
            chk($sformatf("arb.ld_ack[%0d]", k), 32'(ld_ack), 32'(exp_ld));
            chk($sformatf("arb.fe_ack[%0d]", k), 32'(fe_ack), 32'(exp_fe));
        end
        ld_req = 1'b0; fe_req = 1'b0;
        tick();

        // 4. preload 0x00..0x03, then back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_add = 8'(i); ld_data = 8'(8'h11 * (i + 1));
            tick();
            chk($sformatf("pre.ld_ack[%0d]", i), 32'(ld_ack), 32'h1);
            ld_req = 1'b0;
            tick();
        end
        fe_req = 1'b1; fe_add = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("seq.fe_ack[%0d]", i), 32'(fe_ack), 32'h1);
            if (i == 3) fe_req = 1'b0;
            else fe_add = 8'(i + 1);
            tick();
            chk($sformatf("seq.novalid[%0d]", i), 32'(fe_valid), 32'h0);
            tick();
            chk($sformatf("seq.fe_valid[%0d]", i), 32'(fe_valid), 32'h1);
            chk($sformatf("seq.fe_data[%0d]", i),  32'(fe_data),  32'(8'h11 * (i + 1)));
        end
        tick();

        // 5. reset during READ aborts the fetch and clears mem[0]
        fe_req = 1'b1; fe_add = 8'h00;
        tick();
        chk("abort.fe_ack", 32'(fe_ack), 32'h1);
        fe_req = 1'b0;
        reset  = 1'b1;
        tick();
        chk_reset_vals("abort");
        tick();
        chk("abort2.fe_valid", 32'(fe_valid), 32'h0);
        reset = 1'b0;
        tick();
        chk("abort3.fe_valid", 32'(fe_valid), 32'h0);
        chk("abort3.busy",     32'(busy),     32'h0);
        fe_req = 1'b1; fe_add = 8'h00;
        tick();
        chk("post.fe_ack", 32'(fe_ack), 32'h1);
        fe_req = 1'b0;
        tick(); tick();
        chk("post.fe_valid", 32'(fe_valid), 32'h1);
        chk("post.fe_data",  32'(fe_data),  32'h00);
        tick();

        // 6. top address 0xFF with a concurrent fetch of 0x00
        ld_req = 1'b1; ld_add = 8'hFF; ld_data = 8'h5A;
        fe_req = 1'b1; fe_add = 8'h00;
        tick();
        chk("top.ld_ack",  32'(ld_ack),  32'h1);
        chk("top.fe_ack",  32'(fe_ack),  32'h0);
        chk("top.mem_add", 32'(mem_add), 32'hFF);
        ld_req = 1'b0;
        tick();
        chk("top.wait_fe", 32'(fe_ack), 32'h0);
        tick();
        chk("top.fe0_ack", 32'(fe_ack),  32'h1);
        chk("top.fe0_add", 32'(mem_add), 32'h00);
        fe_add = 8'hFF;
        tick(); tick();
        chk("top.fe0_valid", 32'(fe_valid), 32'h1);
        chk("top.fe0_data",  32'(fe_data),  32'h00);
        tick();
        chk("top.feff_ack", 32'(fe_ack),  32'h1);
        chk("top.feff_add", 32'(mem_add), 32'hFF);
        fe_req = 1'b0;
        tick(); tick();
        chk("top.feff_valid", 32'(fe_valid), 32'h1);
        chk("top.feff_data",  32'(fe_data),  32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
